ps2_rx_periph: RTL and testbench

PS2_RX_PERIPH -- requirements
Module: ps2_rx_periph

---
 rtl/ps2_rx_periph_pkg.sv | 28 ++
 rtl/ps2_rx_frame.sv | 112 +++++++++++
 rtl/ps2_rx_periph.sv | 129 ++++++++++++
 tb/tb_ps2_rx_periph.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/ps2_rx_periph_pkg.sv
// Shared definitions for the PS/2 receive peripheral: register map,
// STATUS/CTRL bit positions and receive FSM state encoding.
package ps2_rx_periph_pkg;

    localparam logic [1:0] ADDR_DATA   = 2'd0;
    localparam logic [1:0] ADDR_STATUS = 2'd1;
    localparam logic [1:0] ADDR_CTRL   = 2'd2;
    localparam logic [1:0] ADDR_RSVD   = 2'd3;

    localparam int ST_EMPTY      = 0;
    localparam int ST_FULL       = 1;
    localparam int ST_PARITY_ERR = 2;
    localparam int ST_FRAME_ERR  = 3;
    localparam int ST_OVERFLOW   = 4;
    localparam int ST_COUNT_LSB  = 5;
    localparam int ST_COUNT_W    = 4;

    localparam int CTRL_FLUSH = 0;
    localparam int CTRL_CLEAR = 1;

    typedef enum logic [1:0] {
        RX_IDLE   = 2'd0,
        RX_DATA   = 2'd1,
        RX_PARITY = 2'd2,
        RX_STOP   = 2'd3
    } rx_state_t;

endpackage

// File: rtl/ps2_rx_frame.sv
// PS/2 frame receiver: pin synchronizers, falling-edge detect, frame FSM
// and inactivity timeout. Emits one registered pulse per finished frame.
module ps2_rx_frame
    import ps2_rx_periph_pkg::*;
#(
    parameter int TIMEOUT_CYC = 5000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [7:0] rx_byte,
    output logic       byte_valid,
    output logic       parity_err_p,
    output logic       frame_err_p,
    output rx_state_t  state
);

    localparam int TO_W = $clog2(TIMEOUT_CYC + 1);

    logic [1:0]      clk_sync;
    logic [1:0]      data_sync;
    logic            clk_prev;
    logic            fall;
    logic            sample;
    logic            timeout;
    logic            parity_ok;
    rx_state_t       state_q;
    rx_state_t       state_d;
    logic [2:0]      bit_cnt;
    logic [7:0]      shift;
    logic            parity_bit;
    logic [TO_W-1:0] to_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            clk_sync  <= 2'b11;
            data_sync <= 2'b11;
            clk_prev  <= 1'b1;
        end else begin
            clk_sync  <= {clk_sync[0], ps2_clk};
            data_sync <= {data_sync[0], ps2_data};
            clk_prev  <= clk_sync[1];
        end
    end

    assign fall      = clk_prev & ~clk_sync[1];
    assign sample    = data_sync[1];
    assign parity_ok = ^{shift, parity_bit};
    // Fires on the last of TIMEOUT_CYC consecutive edge-free cycles mid-frame.
    assign timeout   = (state_q != RX_IDLE) && !fall &&
                       (to_cnt == TO_W'(TIMEOUT_CYC - 1));
    assign state     = state_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= RX_IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (timeout) begin
            state_d = RX_IDLE;
        end else if (fall) begin
            case (state_q)
                RX_IDLE:   if (!sample) state_d = RX_DATA;
                RX_DATA:   if (bit_cnt == 3'd7) state_d = RX_PARITY;
                RX_PARITY: state_d = RX_STOP;
                RX_STOP:   state_d = RX_IDLE;
                default:   state_d = RX_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bit_cnt      <= 3'd0;
            shift        <= 8'd0;
            parity_bit   <= 1'b0;
            to_cnt       <= '0;
            rx_byte      <= 8'd0;
            byte_valid   <= 1'b0;
            parity_err_p <= 1'b0;
            frame_err_p  <= 1'b0;
        end else begin
            byte_valid   <= 1'b0;
            parity_err_p <= 1'b0;
            frame_err_p  <= 1'b0;
            if (state_q == RX_IDLE || fall) to_cnt <= '0;
            else                            to_cnt <= to_cnt + TO_W'(1);
            if (fall) begin
                case (state_q)
                    RX_IDLE: bit_cnt <= 3'd0;
                    RX_DATA: begin
                        shift   <= {sample, shift[7:1]};
                        bit_cnt <= bit_cnt + 3'd1;
                    end
                    RX_PARITY: parity_bit <= sample;
                    RX_STOP: begin
                        rx_byte <= shift;
                        // A bad stop bit outranks a bad parity bit.
                        if (!sample)         frame_err_p  <= 1'b1;
                        else if (!parity_ok) parity_err_p <= 1'b1;
                        else                 byte_valid   <= 1'b1;
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: rtl/ps2_rx_periph.sv
// Bus-mapped PS/2 receiver: byte FIFO, sticky error flags and the
// DATA/STATUS/CTRL register decode around the ps2_rx_frame receiver.
module ps2_rx_periph
    import ps2_rx_periph_pkg::*;
#(
    parameter int DATA_W      = 32,
    parameter int FIFO_DEPTH  = 8,
    parameter int TIMEOUT_CYC = 5000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              sel,
    input  logic              rw_req,
    input  logic              rw_rnw,
    input  logic [1:0]        rw_addr,
    input  logic [DATA_W-1:0] data_to_wr,
    output logic [DATA_W-1:0] data_to_rd,
    input  logic              ps2_clk,
    input  logic              ps2_data
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [7:0]        mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [CNT_W-1:0]  count;
    logic              parity_err;
    logic              frame_err;
    logic              overflow;
    logic [7:0]        rx_byte;
    logic              byte_valid;
    logic              parity_err_p;
    logic              frame_err_p;
    rx_state_t         frame_state;
    logic              access;
    logic              rd_data;
    logic              wr_ctrl;
    logic              flush;
    logic              clear;
    logic              empty;
    logic              full;
    logic              pop;
    logic              push;
    logic              ovf_set;
    logic [DATA_W-1:0] status;
    logic              unused_ok;

    ps2_rx_frame #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_frame (
        .clk          (clk),
        .rst          (rst),
        .ps2_clk      (ps2_clk),
        .ps2_data     (ps2_data),
        .rx_byte      (rx_byte),
        .byte_valid   (byte_valid),
        .parity_err_p (parity_err_p),
        .frame_err_p  (frame_err_p),
        .state        (frame_state)
    );

    assign unused_ok = ^{data_to_wr[DATA_W-1:CTRL_CLEAR+1], frame_state};

    assign access  = sel & rw_req;
    assign rd_data = access & rw_rnw & (rw_addr == ADDR_DATA);
    assign wr_ctrl = access & ~rw_rnw & (rw_addr == ADDR_CTRL);
    assign flush   = wr_ctrl & data_to_wr[CTRL_FLUSH];
    assign clear   = wr_ctrl & data_to_wr[CTRL_CLEAR];
    assign empty   = (count == '0);
    assign full    = (count == CNT_W'(FIFO_DEPTH));
    assign pop     = rd_data & ~empty;
    // A pop in the same cycle frees the slot, so a full FIFO can still accept.
    assign push    = byte_valid & ~flush & (~full | pop);
    assign ovf_set = byte_valid & ~flush & full & ~pop;

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= rx_byte;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
            overflow   <= 1'b0;
        end else begin
            if (flush) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
                count  <= '0;
            end else begin
                if (push) wr_ptr <= wr_ptr + PTR_W'(1);
                if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
                case ({push, pop})
                    2'b10:   count <= count + CNT_W'(1);
                    2'b01:   count <= count - CNT_W'(1);
                    default: ;
                endcase
            end
            parity_err <= (parity_err & ~clear) | parity_err_p;
            frame_err  <= (frame_err  & ~clear) | frame_err_p;
            overflow   <= (overflow   & ~clear) | ovf_set;
        end
    end

    always_comb begin
        status = '0;
        status[ST_EMPTY]      = empty;
        status[ST_FULL]       = full;
        status[ST_PARITY_ERR] = parity_err;
        status[ST_FRAME_ERR]  = frame_err;
        status[ST_OVERFLOW]   = overflow;
        status[ST_COUNT_LSB +: ST_COUNT_W] = ST_COUNT_W'(count);
    end

    always_comb begin
        data_to_rd = '0;
        if (access && rw_rnw) begin
            case (rw_addr)
                ADDR_DATA:   if (!empty) data_to_rd[7:0] = mem[rd_ptr];
                ADDR_STATUS: data_to_rd = status;
                default:     ;
            endcase
        end
    end

endmodule

// File: tb/tb_ps2_rx_periph.sv
// Bench for ps2_rx_periph: directed PS/2 frames with a queue-based model
// of the buffered bytes and flags, checked on every bus read.
module tb_ps2_rx_periph;

    localparam int DATA_W = 32;
    localparam int DEPTH  = 8;
    localparam int TMO    = 200;
    localparam int HALF   = 20;

    logic              clk = 1'b0;
    logic              rst;
    logic              sel;
    logic              rw_req;
    logic              rw_rnw;
    logic [1:0]        rw_addr;
    logic [DATA_W-1:0] data_to_wr;
    logic [DATA_W-1:0] data_to_rd;
    logic              ps2_clk;
    logic              ps2_data;

    int checks = 0;
    int errors = 0;

    logic [7:0] exp_q[$];
    logic       m_perr;
    logic       m_ferr;
    logic       m_ovf;
    logic [DATA_W-1:0] v;

    always #5 clk = ~clk;

    ps2_rx_periph #(.DATA_W(DATA_W), .FIFO_DEPTH(DEPTH), .TIMEOUT_CYC(TMO)) dut (
        .clk        (clk),
        .rst        (rst),
        .sel        (sel),
        .rw_req     (rw_req),
        .rw_rnw     (rw_rnw),
        .rw_addr    (rw_addr),
        .data_to_wr (data_to_wr),
        .data_to_rd (data_to_rd),
        .ps2_clk    (ps2_clk),
        .ps2_data   (ps2_data)
    );

    task automatic check(input string name, input logic [DATA_W-1:0] act,
                         input logic [DATA_W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [DATA_W-1:0] model_status();
        int n;
        n = exp_q.size();
        return DATA_W'((n == 0 ? 1 : 0) + (n == DEPTH ? 2 : 0) + 4 * int'(m_perr)
                       + 8 * int'(m_ferr) + 16 * int'(m_ovf) + 32 * n);
    endfunction

    // Reads are checked against the model; CTRL writes update it.
    always @(negedge clk) begin
        if (!rst && sel && rw_req) begin
            if (rw_rnw) begin
                case (rw_addr)
                    2'd0: begin
                        if (exp_q.size() != 0) begin
                            check("data_rd", data_to_rd, DATA_W'(exp_q[0]));
                            void'(exp_q.pop_front());
                        end else begin
                            check("data_rd_empty", data_to_rd, '0);
                        end
                    end
                    2'd1:    check("status_rd", data_to_rd, model_status());
                    2'd3:    check("rsvd_rd", data_to_rd, '0);
                    default: ;
                endcase
            end else if (rw_addr == 2'd2) begin
                if (data_to_wr[1]) begin
                    m_perr = 1'b0;
                    m_ferr = 1'b0;
                    m_ovf  = 1'b0;
                end
                if (data_to_wr[0]) exp_q.delete();
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: time limit reached, expected end of stimulus");
        $fatal(1, "watchdog");
    end

    task automatic bus_write(input logic [1:0] a, input logic [DATA_W-1:0] d);
        sel = 1'b1; rw_req = 1'b1; rw_rnw = 1'b0; rw_addr = a; data_to_wr = d;
        @(posedge clk);
        #1 sel = 1'b0; rw_req = 1'b0; data_to_wr = '0;
    endtask

    task automatic bus_read(input logic [1:0] a, output logic [DATA_W-1:0] val);
        sel = 1'b1; rw_req = 1'b1; rw_rnw = 1'b1; rw_addr = a;
        @(negedge clk);
        val = data_to_rd;
        @(posedge clk);
        #1 sel = 1'b0; rw_req = 1'b0;
    endtask

    // act: 0 none, 1 CTRL flush, 2 DATA read -- aligned with the FIFO push
    // that a stop-bit fall causes four clk edges later.
    task automatic ps2_bit(input logic b, input int act);
        logic [DATA_W-1:0] tmp;
        ps2_data = b;
        repeat (HALF) @(posedge clk);
        #1 ps2_clk = 1'b0;
        if (act != 0) begin
            repeat (3) @(posedge clk);
            #1;
            if (act == 1) bus_write(2'd2, 32'h1);
            else          bus_read(2'd0, tmp);
            repeat (HALF - 4) @(posedge clk);
        end else begin
            repeat (HALF) @(posedge clk);
        end
        #1 ps2_clk = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] d, input logic par_flip,
                              input logic stop, input int act);
        logic [10:0] bits;
        bits = {stop, ~(^d) ^ par_flip, d, 1'b0};
        for (int i = 0; i < 11; i++) ps2_bit(bits[i], (i == 10) ? act : 0);
        ps2_data = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        if (!stop)                   m_ferr = 1'b1;
        else if (par_flip)           m_perr = 1'b1;
        else if (act == 1)           ;
        else if (exp_q.size() == DEPTH) m_ovf = 1'b1;
        else                         exp_q.push_back(d);
    endtask

    task automatic send_partial(input logic [7:0] d, input int nbits);
        ps2_bit(1'b0, 0);
        for (int i = 0; i < nbits; i++) ps2_bit(d[i], 0);
        ps2_data = 1'b1;
    endtask

    initial begin
        rst = 1'b1; sel = 1'b0; rw_req = 1'b0; rw_rnw = 1'b0; rw_addr = 2'd0;
        data_to_wr = '0; ps2_clk = 1'b1; ps2_data = 1'b1;
        m_perr = 1'b0; m_ferr = 1'b0; m_ovf = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk);
        #1;

        bus_read(2'd1, v); check("reset_status", v, 32'h001);
        bus_read(2'd0, v); check("reset_data", v, 32'h000);

        send_frame(8'h1C, 1'b0, 1'b1, 0);
        bus_read(2'd1, v); check("good_status", v, 32'h020);
        bus_read(2'd0, v); check("good_data", v, 32'h01C);
        bus_read(2'd1, v); check("good_status_after", v, 32'h001);

        send_frame(8'h1C, 1'b1, 1'b1, 0);
        bus_read(2'd1, v); check("parity_status", v, 32'h005);
        bus_write(2'd2, 32'h2);
        bus_read(2'd1, v); check("parity_cleared", v, 32'h001);

        send_frame(8'hA5, 1'b0, 1'b0, 0);
        bus_read(2'd1, v); check("frame_err_status", v, 32'h009);
        bus_write(2'd2, 32'h2);
        bus_write(2'd3, 32'hFFFF_FFFF);
        bus_read(2'd3, v); check("rsvd_lit", v, 32'h000);
        bus_read(2'd1, v); check("after_rsvd_write", v, 32'h001);

        for (int i = 1; i <= 9; i++) send_frame(8'(i), 1'b0, 1'b1, 0);
        bus_read(2'd1, v); check("overflow_status", v, 32'h112);
        for (int i = 0; i < 9; i++) begin
            bus_read(2'd0, v);
            check("overflow_drain", v, (i < 8) ? DATA_W'(i + 1) : '0);
        end
        bus_read(2'd1, v); check("overflow_sticky", v, 32'h011);
        bus_write(2'd2, 32'h2);

        for (int i = 0; i < 8; i++) send_frame(8'(8'h30 + i), 1'b0, 1'b1, 0);
        bus_read(2'd1, v); check("full_status", v, 32'h102);
        send_frame(8'h40, 1'b0, 1'b1, 2);
        bus_read(2'd1, v); check("full_push_pop", v, 32'h102);
        for (int i = 0; i < 8; i++) begin
            bus_read(2'd0, v);
            check("full_drain", v, (i < 7) ? DATA_W'(8'h31 + i) : 32'h040);
        end
        bus_read(2'd1, v); check("full_drained", v, 32'h001);

        send_partial(8'h55, 3);
        repeat (TMO + 1) @(posedge clk);
        #1;
        send_frame(8'hF0, 1'b0, 1'b1, 0);
        bus_read(2'd1, v); check("timeout_status", v, 32'h020);
        bus_read(2'd0, v); check("timeout_data", v, 32'h0F0);

        for (int i = 0; i < 3; i++) send_frame(8'(8'h61 + i), 1'b0, 1'b1, 0);
        bus_read(2'd1, v); check("three_buffered", v, 32'h060);
        send_frame(8'h64, 1'b0, 1'b1, 1);
        bus_read(2'd1, v); check("flush_vs_push", v, 32'h001);

        send_frame(8'h11, 1'b0, 1'b1, 0);
        send_partial(8'hC3, 5);
        rst = 1'b1;
        exp_q.delete();
        m_perr = 1'b0; m_ferr = 1'b0; m_ovf = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk);
        #1;
        bus_read(2'd1, v); check("midframe_reset_status", v, 32'h001);
        send_frame(8'h5A, 1'b0, 1'b1, 0);
        bus_read(2'd1, v); check("post_reset_status", v, 32'h020);
        bus_read(2'd0, v); check("post_reset_data", v, 32'h05A);
        bus_read(2'd0, v); check("post_reset_empty", v, 32'h000);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
